// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: controller states,
// array dimension and the length of the diagonal skew window.
package systolic_feeder_pkg;

   localparam int N        = 3;
   localparam int SKEW_LEN = 2 * N - 1;
   localparam int STEP_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FEED = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Position inside a lane's three-element window for a given skew step.
   function automatic int lane_offset(input logic [STEP_W-1:0] step, input int lane);
      return int'(step) - lane;
   endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skewed stream: emits element (step - LANE) of its three stored
// elements while feeding, zero outside that window or when not feeding.
module systolic_feeder_skew_lane
   import systolic_feeder_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int LANE      = 0
)
(
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 active,
   input  logic [STEP_W-1:0]    step,
   input  logic [DATAWIDTH-1:0] e0,
   input  logic [DATAWIDTH-1:0] e1,
   input  logic [DATAWIDTH-1:0] e2,
   output logic [DATAWIDTH-1:0] q
);

   logic [DATAWIDTH-1:0] q_reg;
   logic [DATAWIDTH-1:0] q_next;

   // Select the element that falls on this lane's diagonal for the coming step.
   always_comb begin
      int k;
      k      = lane_offset(step, LANE);
      q_next = '0;
      if (active) begin
         case (k)
            0:       q_next = e0;
            1:       q_next = e1;
            2:       q_next = e2;
            default: q_next = '0;
         endcase
      end
   end

   // Register the stream value so the array sees a clean flop output.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) q_reg <= '0;
      else       q_reg <= q_next;
   end

   assign q = q_reg;

endmodule

// File: rtl/systolic_feeder.sv
// Feeder for the 3x3 systolic multiplier: stores A and B operands, streams
// them diagonally skewed on launch, then waits for the array's Done or times out.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int TIMEOUT   = 15
)
(
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [1:0]           wr_row,
   input  logic [1:0]           wr_col,
   input  logic [DATAWIDTH-1:0] wr_data,
   input  logic                 go,
   input  logic                 arr_done,
   output logic                 start,
   output logic [DATAWIDTH-1:0] A0,
   output logic [DATAWIDTH-1:0] A1,
   output logic [DATAWIDTH-1:0] A2,
   output logic [DATAWIDTH-1:0] B0,
   output logic [DATAWIDTH-1:0] B1,
   output logic [DATAWIDTH-1:0] B2,
   output logic                 ready,
   output logic                 done,
   output logic                 err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t               state_reg, state_next;
   logic [STEP_W-1:0]    step_reg, step_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 start_reg, start_next;
   logic                 ready_reg, ready_next;
   logic                 done_reg, done_next;
   logic                 err_reg, err_next;
   logic                 feed_active;

   logic [DATAWIDTH-1:0] mat_a_reg  [N][N];
   logic [DATAWIDTH-1:0] mat_b_reg  [N][N];
   logic [DATAWIDTH-1:0] mat_a_next [N][N];
   logic [DATAWIDTH-1:0] mat_b_next [N][N];

   logic [DATAWIDTH-1:0] a_stream [N];
   logic [DATAWIDTH-1:0] b_stream [N];

   // Apply an element write while idle; the lanes read this updated view so a
   // write coinciding with go is already visible in the first feed step.
   always_comb begin
      mat_a_next = mat_a_reg;
      mat_b_next = mat_b_reg;
      if (state_reg == ST_IDLE && wr_en && wr_row != 2'd3 && wr_col != 2'd3) begin
         if (wr_sel) mat_b_next[wr_row][wr_col] = wr_data;
         else        mat_a_next[wr_row][wr_col] = wr_data;
      end
   end

   // Operand storage, cleared on reset and kept across runs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mat_a_reg[r][c] <= '0;
               mat_b_reg[r][c] <= '0;
            end
         end
      end else begin
         mat_a_reg <= mat_a_next;
         mat_b_reg <= mat_b_next;
      end
   end

   // Next-state and registered-output values; done takes priority over timeout.
   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (go) begin
               state_next = ST_FEED;
               step_next  = '0;
               cnt_next   = CNT_W'(1);
            end
         end
         ST_FEED, ST_WAIT: begin
            if (arr_done) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
               state_next = ST_IDLE;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
               if (state_reg == ST_FEED) begin
                  if (step_reg == STEP_W'(SKEW_LEN - 1)) state_next = ST_WAIT;
                  else                                   step_next  = step_reg + 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      start_next  = (state_next != ST_IDLE);
      ready_next  = (state_next == ST_IDLE);
      feed_active = (state_next == ST_FEED);
   end

   // Controller state and handshake outputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_reg <= ST_IDLE;
         step_reg  <= '0;
         cnt_reg   <= '0;
         start_reg <= 1'b0;
         ready_reg <= 1'b1;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         cnt_reg   <= cnt_next;
         start_reg <= start_next;
         ready_reg <= ready_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   // Row lane gi streams A[gi][*]; column lane gi streams B[*][gi].
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      systolic_feeder_skew_lane #(.DATAWIDTH(DATAWIDTH), .LANE(gi)) u_a_lane (
         .CLK    (CLK),
         .RSTn   (RSTn),
         .active (feed_active),
         .step   (step_next),
         .e0     (mat_a_next[gi][0]),
         .e1     (mat_a_next[gi][1]),
         .e2     (mat_a_next[gi][2]),
         .q      (a_stream[gi])
      );
      systolic_feeder_skew_lane #(.DATAWIDTH(DATAWIDTH), .LANE(gi)) u_b_lane (
         .CLK    (CLK),
         .RSTn   (RSTn),
         .active (feed_active),
         .step   (step_next),
         .e0     (mat_b_next[0][gi]),
         .e1     (mat_b_next[1][gi]),
         .e2     (mat_b_next[2][gi]),
         .q      (b_stream[gi])
      );
   end

   assign start = start_reg;
   assign ready = ready_reg;
   assign done  = done_reg;
   assign err   = err_reg;
   assign A0    = a_stream[0];
   assign A1    = a_stream[1];
   assign A2    = a_stream[2];
   assign B0    = b_stream[0];
   assign B1    = b_stream[1];
   assign B2    = b_stream[2];

endmodule
